// File: rtl/expr_string.sv
// expr_string: streaming recogniser for infix arithmetic expressions.
// One ASCII character is consumed per cycle with in_valid high. out reports
// whether the prefix consumed so far is a complete, well-formed expression.
// err is sticky until clr.
module expr_string #(
    parameter int unsigned MAX_DIGITS = 4,
    parameter int unsigned MAX_DEPTH  = 7,
    parameter int unsigned EXT_OPS    = 0,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                             clk,
    input  logic                             clr,
    input  logic [7:0]                       in,
    input  logic                             in_valid,
    output logic                             out,
    output logic                             err,
    output logic [$clog2(MAX_DEPTH+1)-1:0]   depth,
    output logic [CNT_W-1:0]                 opnd_cnt
);

    localparam int unsigned DEP_W = $clog2(MAX_DEPTH + 1);
    localparam int unsigned DC_W  = $clog2(MAX_DIGITS + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // FSM states
    localparam logic [1:0] S_OPND  = 2'd0;
    localparam logic [1:0] S_NUM   = 2'd1;
    localparam logic [1:0] S_CLOSE = 2'd2;
    localparam logic [1:0] S_ERR   = 2'd3;

    // Character classes
    localparam logic [2:0] C_DIG = 3'd0;
    localparam logic [2:0] C_OP  = 3'd1;
    localparam logic [2:0] C_LP  = 3'd2;
    localparam logic [2:0] C_RP  = 3'd3;
    localparam logic [2:0] C_BAD = 3'd4;

    logic [1:0]       state_q, state_d;
    logic [DEP_W-1:0] depth_q, depth_d;
    logic [DC_W-1:0]  dcnt_q,  dcnt_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             out_q,   out_d;
    logic             err_q,   err_d;
    logic [2:0]       cls_c;

    // Classify the incoming character
    always_comb begin
        cls_c = C_BAD;
        if ((in >= 8'h30) && (in <= 8'h39)) begin
            cls_c = C_DIG;
        end else begin
            case (in)
                8'h2B, 8'h2A: cls_c = C_OP;
                8'h2D, 8'h2F: cls_c = (EXT_OPS != 0) ? C_OP : C_BAD;
                8'h28:        cls_c = C_LP;
                8'h29:        cls_c = C_RP;
                default:      cls_c = C_BAD;
            endcase
        end
    end

    // Next state; counters are left untouched on any transition into S_ERR
    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        dcnt_d  = dcnt_q;
        cnt_d   = cnt_q;
        if (in_valid) begin
            case (state_q)
                S_OPND: begin
                    if (cls_c == C_DIG) begin
                        state_d = S_NUM;
                        dcnt_d  = DC_W'(1);
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else if (cls_c == C_LP) begin
                        if (depth_q == DEP_W'(MAX_DEPTH)) begin
                            state_d = S_ERR;
                        end else begin
                            depth_d = depth_q + 1'b1;
                        end
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_NUM: begin
                    if (cls_c == C_DIG) begin
                        if (dcnt_q == DC_W'(MAX_DIGITS)) begin
                            state_d = S_ERR;
                        end else begin
                            dcnt_d = dcnt_q + 1'b1;
                        end
                    end else if (cls_c == C_OP) begin
                        state_d = S_OPND;
                    end else if (cls_c == C_RP) begin
                        if (depth_q == '0) begin
                            state_d = S_ERR;
                        end else begin
                            state_d = S_CLOSE;
                            depth_d = depth_q - 1'b1;
                        end
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_CLOSE: begin
                    if (cls_c == C_OP) begin
                        state_d = S_OPND;
                    end else if (cls_c == C_RP) begin
                        if (depth_q == '0) begin
                            state_d = S_ERR;
                        end else begin
                            depth_d = depth_q - 1'b1;
                        end
                    end else begin
                        state_d = S_ERR;
                    end
                end
                default: begin
                    state_d = S_ERR;
                end
            endcase
        end
        out_d = ((state_d == S_NUM) || (state_d == S_CLOSE)) && (depth_d == '0);
        err_d = (state_d == S_ERR);
    end

    // State, counters and status flags
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_OPND;
            depth_q <= '0;
            dcnt_q  <= '0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            dcnt_q  <= dcnt_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

    assign out      = out_q;
    assign err      = err_q;
    assign depth    = depth_q;
    assign opnd_cnt = cnt_q;

endmodule

// File: tb/tb_expr_string.sv
// Testbench for expr_string: EXT_OPS=0 and EXT_OPS=1 instances share stimulus
// and are checked against a token-adjacency reference model.
module tb_expr_string;

    localparam int MAXD = 4;
    localparam int MAXP = 7;

    localparam int P_START = 0;
    localparam int P_DIG   = 1;
    localparam int P_OP    = 2;
    localparam int P_LP    = 3;
    localparam int P_RP    = 4;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       vld = 1'b0;
    logic [7:0] ch  = 8'h00;

    logic       out0, err0, out1, err1;
    logic [2:0] dep0, dep1;
    logic [7:0] cnt0, cnt1;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state, one entry per operator mode
    bit m_err   [2];
    int m_prev  [2];
    int m_depth [2];
    int m_run   [2];
    int m_cnt   [2];

    expr_string #(.MAX_DIGITS(MAXD), .MAX_DEPTH(MAXP), .EXT_OPS(0), .CNT_W(8)) dut0 (
        .clk(clk), .clr(clr), .in(ch), .in_valid(vld),
        .out(out0), .err(err0), .depth(dep0), .opnd_cnt(cnt0)
    );

    expr_string #(.MAX_DIGITS(MAXD), .MAX_DEPTH(MAXP), .EXT_OPS(1), .CNT_W(8)) dut1 (
        .clk(clk), .clr(clr), .in(ch), .in_valid(vld),
        .out(out1), .err(err1), .depth(dep1), .opnd_cnt(cnt1)
    );

    always #5 clk = ~clk;

    wire [12:0] obs0 = {out0, err0, dep0, cnt0};
    wire [12:0] obs1 = {out1, err1, dep1, cnt1};

    function automatic void m_reset();
        for (int k = 0; k < 2; k++) begin
            m_err[k] = 1'b0; m_prev[k] = P_START; m_depth[k] = 0;
            m_run[k] = 0;    m_cnt[k]  = 0;
        end
    endfunction

    // A character is legal when it may follow the previous token
    function automatic void m_step(input logic [7:0] c);
        for (int k = 0; k < 2; k++) begin
            bit dig, op, lp, rp, want_opnd, after_opnd;
            dig = (c >= "0") && (c <= "9");
            op  = (c == "+") || (c == "*") || ((k == 1) && ((c == "-") || (c == "/")));
            lp  = (c == "(");
            rp  = (c == ")");
            want_opnd  = (m_prev[k] == P_START) || (m_prev[k] == P_OP) || (m_prev[k] == P_LP);
            after_opnd = (m_prev[k] == P_DIG) || (m_prev[k] == P_RP);
            if (!m_err[k]) begin
                if (dig && want_opnd) begin
                    m_prev[k] = P_DIG; m_run[k] = 1;
                    if (m_cnt[k] < 255) m_cnt[k]++;
                end else if (dig && m_prev[k] == P_DIG && m_run[k] < MAXD) begin
                    m_run[k]++;
                end else if (op && after_opnd) begin
                    m_prev[k] = P_OP;
                end else if (lp && want_opnd && m_depth[k] < MAXP) begin
                    m_depth[k]++; m_prev[k] = P_LP;
                end else if (rp && after_opnd && m_depth[k] > 0) begin
                    m_depth[k]--; m_prev[k] = P_RP;
                end else begin
                    m_err[k] = 1'b1;
                end
            end
        end
    endfunction

    function automatic logic [12:0] m_vec(input int k);
        logic o;
        o = !m_err[k] && (m_prev[k] == P_DIG || m_prev[k] == P_RP) && (m_depth[k] == 0);
        return {o, m_err[k], 3'(m_depth[k]), 8'(m_cnt[k])};
    endfunction

    // Present one character after `gap` idle cycles with junk on the bus
    task automatic send(input logic [7:0] c, input int gap);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk); vld = 1'b0; ch = 8'($urandom);
        end
        @(negedge clk); ch = c; vld = 1'b1;
        @(posedge clk); m_step(c);
        #1 vld = 1'b0;
    endtask

    task automatic do_clr();
        @(negedge clk); clr = 1'b1; vld = 1'b0;
        @(negedge clk); clr = 1'b0; m_reset();
    endtask

    task automatic test_reset();
        string s = "1+2*3";
        logic exp_out [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        @(negedge clk);
        n_cmp++;
        if (obs0 !== 13'd0 || obs1 !== 13'd0) begin
            n_fail++; $display("FAIL reset_state: got %h/%h want 0", obs0, obs1);
        end
        do_clr();
        for (int i = 0; i < s.len(); i++) begin
            send(s[i], 0);
            n_cmp++;
            if (out0 !== exp_out[i] || obs0 !== m_vec(0)) begin
                n_fail++; $display("FAIL reset_stream[%0d]: got %h want out=%b model %h", i, obs0, exp_out[i], m_vec(0));
            end
        end
        n_cmp++;
        if (cnt0 !== 8'd3 || err0 !== 1'b0) begin
            n_fail++; $display("FAIL reset_cnt: got cnt=%0d err=%b want cnt=3 err=0", cnt0, err0);
        end
    endtask

    task automatic test_multidigit();
        string s = "1234+56";
        logic exp_out [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        do_clr();
        for (int i = 0; i < s.len(); i++) begin
            send(s[i], 0);
            n_cmp++;
            if (out0 !== exp_out[i] || obs0 !== m_vec(0)) begin
                n_fail++; $display("FAIL multidigit[%0d]: got %h want out=%b model %h", i, obs0, exp_out[i], m_vec(0));
            end
        end
        n_cmp++;
        if (cnt0 !== 8'd2) begin
            n_fail++; $display("FAIL multidigit_cnt: got %0d want 2", cnt0);
        end
        do_clr();
        s = "12345";
        for (int i = 0; i < s.len(); i++) begin
            send(s[i], 0);
            n_cmp++;
            if (err0 !== (i == 4) || obs0 !== m_vec(0)) begin
                n_fail++; $display("FAIL digit_limit[%0d]: got %h want err=%b model %h", i, obs0, (i == 4), m_vec(0));
            end
        end
        n_cmp++;
        if (out0 !== 1'b0 || cnt0 !== 8'd1) begin
            n_fail++; $display("FAIL digit_limit_end: got out=%b cnt=%0d want 0/1", out0, cnt0);
        end
    endtask

    task automatic test_nesting();
        string s = "((1+2)*3)";
        int exp_dep [9] = '{1, 2, 2, 2, 2, 1, 1, 1, 0};
        do_clr();
        for (int i = 0; i < s.len(); i++) begin
            send(s[i], 0);
            n_cmp++;
            if (dep0 !== 3'(exp_dep[i]) || out0 !== (i == 8) || obs0 !== m_vec(0)) begin
                n_fail++; $display("FAIL nesting[%0d]: got %h want depth=%0d out=%b", i, obs0, exp_dep[i], (i == 8));
            end
        end
        do_clr();
        for (int i = 0; i < 8; i++) begin
            send("(", 0);
            n_cmp++;
            if (err0 !== (i == 7) || dep0 !== 3'((i < 7) ? i + 1 : 7)) begin
                n_fail++; $display("FAIL depth_limit[%0d]: got err=%b depth=%0d", i, err0, dep0);
            end
        end
    endtask

    task automatic test_malformed();
        string bad [4] = '{")1", "1(", "(1)2", "1++2"};
        int    at  [4] = '{1, 2, 4, 3};
        string ok = "0123456789+*()";
        for (int t = 0; t < 4; t++) begin
            do_clr();
            for (int i = 0; i < bad[t].len(); i++) begin
                send(bad[t][i], 0);
                n_cmp++;
                if (err0 !== (i + 1 >= at[t]) || obs0 !== m_vec(0)) begin
                    n_fail++; $display("FAIL malformed%0d[%0d]: got %h want err=%b", t, i, obs0, (i + 1 >= at[t]));
                end
            end
            for (int i = 0; i < 20; i++) begin
                send(ok[$urandom_range(ok.len() - 1)], 0);
                n_cmp++;
                if (err0 !== 1'b1 || out0 !== 1'b0 || obs0 !== m_vec(0)) begin
                    n_fail++; $display("FAIL sticky%0d[%0d]: got err=%b out=%b want 1/0", t, i, err0, out0);
                end
            end
        end
    endtask

    task automatic test_mode();
        string s = "3-1";
        do_clr();
        for (int i = 0; i < s.len(); i++) begin
            send(s[i], 0);
            n_cmp++;
            if (err0 !== (i >= 1) || err1 !== 1'b0 || obs0 !== m_vec(0) || obs1 !== m_vec(1)) begin
                n_fail++; $display("FAIL mode_minus[%0d]: got %h/%h want err0=%b err1=0", i, obs0, obs1, (i >= 1));
            end
        end
        do_clr();
        s = "8/2-1";
        for (int i = 0; i < s.len(); i++) begin
            send(s[i], 0);
        end
        n_cmp++;
        if (out1 !== 1'b1 || err1 !== 1'b0 || err0 !== 1'b1 || obs1 !== m_vec(1)) begin
            n_fail++; $display("FAIL mode_ext: got out1=%b err1=%b err0=%b want 1/0/1", out1, err1, err0);
        end
    endtask

    task automatic test_gating();
        string s = "(12+3)*45";
        logic [12:0] seq [9];
        do_clr();
        for (int i = 0; i < s.len(); i++) begin
            send(s[i], 0);
            seq[i] = obs0;
        end
        do_clr();
        for (int i = 0; i < s.len(); i++) begin
            logic [12:0] held;
            send(s[i], 1 + $urandom_range(2));
            n_cmp++;
            if (obs0 !== seq[i] || obs0 !== m_vec(0)) begin
                n_fail++; $display("FAIL gating[%0d]: got %h want %h", i, obs0, seq[i]);
            end
            held = m_vec(0);
            for (int g = 0; g < 2; g++) begin
                @(negedge clk); vld = 1'b0; ch = "(";
            end
            n_cmp++;
            if (obs0 !== held) begin
                n_fail++; $display("FAIL gating_hold[%0d]: got %h want %h", i, obs0, held);
            end
        end
    endtask

    task automatic test_async_clr();
        string s = "(12+";
        do_clr();
        for (int i = 0; i < s.len(); i++) send(s[i], 0);
        n_cmp++;
        if (obs0 !== m_vec(0) || dep0 !== 3'd1 || cnt0 !== 8'd1) begin
            n_fail++; $display("FAIL async_pre: got %h want %h", obs0, m_vec(0));
        end
        #3 clr = 1'b1;
        #1;
        n_cmp++;
        if (dep0 !== 3'd0 || out0 !== 1'b0 || cnt0 !== 8'd0) begin
            n_fail++; $display("FAIL async_clear: got depth=%0d out=%b cnt=%0d want 0", dep0, out0, cnt0);
        end
        #2 clr = 1'b0; m_reset();
        send("5", 0);
        n_cmp++;
        if (out0 !== 1'b1 || cnt0 !== 8'd1 || obs0 !== m_vec(0)) begin
            n_fail++; $display("FAIL async_restart: got %h want out=1 cnt=1", obs0);
        end
    endtask

    task automatic test_saturate();
        do_clr();
        for (int i = 0; i < 260; i++) begin
            send("7", 0);
            send("+", 0);
        end
        send("9", 0);
        n_cmp++;
        if (cnt0 !== 8'd255 || err0 !== 1'b0 || out0 !== 1'b1 || obs0 !== m_vec(0)) begin
            n_fail++; $display("FAIL saturate: got cnt=%0d err=%b out=%b want 255/0/1", cnt0, err0, out0);
        end
    endtask

    task automatic test_random();
        string alpha = "0123456789+*-/()(x)+1";
        do_clr();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(49) == 0) do_clr();
            send(alpha[$urandom_range(alpha.len() - 1)], $urandom_range(2));
            n_cmp++;
            if (obs0 !== m_vec(0) || obs1 !== m_vec(1)) begin
                n_fail++; $display("FAIL random[%0d]: got %h/%h want %h/%h", i, obs0, obs1, m_vec(0), m_vec(1));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        m_reset();
        test_reset();
        test_multidigit();
        test_nesting();
        test_malformed();
        test_mode();
        test_gating();
        test_async_clr();
        test_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
